// File: rtl/demux_stream_nch_if.sv
// rtl/demux_stream_nch_if.sv - stream/channel bundle for demux_stream_nch
// slave is the demux view, master is the producer/consumer view.
interface demux_stream_nch_if #(
  parameter int N     = 8,
  parameter int NCH   = 4,
  parameter int SEL_W = 2
);
  logic [N-1:0]     in_data;
  logic             in_valid;
  logic             in_ready;
  logic [SEL_W-1:0] sel;
  logic             mode;
  logic [NCH*N-1:0] out_data;
  logic [NCH-1:0]   out_valid;
  logic [NCH-1:0]   out_ready;
  logic [SEL_W-1:0] rr_ptr;
  logic [7:0]       bad_sel_cnt;

  modport slave (
    input  in_data, in_valid, sel, mode, out_ready,
    output in_ready, out_data, out_valid, rr_ptr, bad_sel_cnt
  );

  modport master (
    output in_data, in_valid, sel, mode, out_ready,
    input  in_ready, out_data, out_valid, rr_ptr, bad_sel_cnt
  );
endinterface

// File: rtl/demux_stream_nch.sv
// rtl/demux_stream_nch.sv - registered 1-to-NCH valid/ready stream demux
// Steered or round-robin routing into per-channel one-entry holding registers.
module demux_stream_nch #(
  parameter int N     = 8,
  parameter int NCH   = 4,
  parameter int SEL_W = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  demux_stream_nch_if.slave     bus
);
  localparam int               NSLOT = 1 << SEL_W;
  localparam logic [SEL_W:0]   NCH_X = (SEL_W+1)'(NCH);
  localparam logic [SEL_W-1:0] RR_LAST = SEL_W'(NCH - 1);

  logic [NCH*N-1:0] out_data_q, out_data_d;
  logic [NCH-1:0]   out_valid_q, out_valid_d;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [7:0]       bad_cnt_q, bad_cnt_d;

  logic [SEL_W-1:0] tgt;
  logic             tgt_ok;
  logic [NSLOT-1:0] vld_ext, rdy_ext, free_ext;
  logic             in_ready;
  logic             accept;
  logic             fill;

  // Pad channel state to the full sel range so free_ext[tgt] is always in bounds.
  always_comb begin
    vld_ext = '0;
    rdy_ext = '0;
    vld_ext[NCH-1:0] = out_valid_q;
    rdy_ext[NCH-1:0] = bus.out_ready;
    free_ext = ~vld_ext | rdy_ext;
  end

  assign tgt      = bus.mode ? rr_ptr_q : bus.sel;
  assign tgt_ok   = ({1'b0, tgt} < NCH_X);
  assign in_ready = rst_n & (tgt_ok ? free_ext[tgt] : 1'b1);
  assign accept   = bus.in_valid & in_ready;
  assign fill     = accept & tgt_ok;

  always_comb begin
    out_valid_d = out_valid_q & ~bus.out_ready;
    out_data_d  = out_data_q;
    rr_ptr_d    = rr_ptr_q;
    bad_cnt_d   = bad_cnt_q;
    // A fill overrides a same-cycle drain so the channel never bubbles.
    for (int k = 0; k < NCH; k++) begin
      if (fill && (tgt == SEL_W'(k))) begin
        out_valid_d[k]        = 1'b1;
        out_data_d[k*N +: N]  = bus.in_data;
      end
    end
    if (accept && bus.mode) begin
      rr_ptr_d = (rr_ptr_q == RR_LAST) ? '0 : rr_ptr_q + 1'b1;
    end
    if (accept && !tgt_ok && (bad_cnt_q != 8'hFF)) begin
      bad_cnt_d = bad_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_valid_q <= '0;
      rr_ptr_q    <= '0;
      bad_cnt_q   <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      rr_ptr_q    <= rr_ptr_d;
      bad_cnt_q   <= bad_cnt_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_data    = out_data_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.rr_ptr      = rr_ptr_q;
  assign bus.bad_sel_cnt = bad_cnt_q;
endmodule
